// File: rtl/wr_fifo_ddr_pkg.sv
// rtl/wr_fifo_ddr_pkg.sv - shared types and sizing helpers for the FIFO-to-DDR burst writer
// Contents: FSM state enum, default byte-size localparams, burst size helper.
package wr_fifo_ddr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   // Sizes for the default configuration (128-bit beats, 64-beat bursts, 1024 bursts/frame)
   localparam int BYTES_PER_BEAT = 128 / 8;
   localparam int BURST_BYTES    = 64 * BYTES_PER_BEAT;
   localparam int FRAME_BYTES    = 1024 * BURST_BYTES;

   // Byte stride of one burst for an arbitrary configuration
   function automatic int burst_bytes(input int data_width, input int burst_len);
      return burst_len * (data_width / 8);
   endfunction

endpackage

// File: rtl/wr_fifo_ddr_skid.sv
// rtl/wr_fifo_ddr_skid.sv - 2-entry skid buffer between the FIFO read port and the AXI W channel
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push_i            : FIFO data valid this cycle (fifo_rd_en delayed by one)
//   push_data_i       : FIFO read data
//   pop_i             : W handshake (wvalid && wready)
//   buf_cnt_o         : words held in the buffer
//   wvalid_o, wdata_o : W channel valid/data
module wr_fifo_ddr_skid
   import wr_fifo_ddr_pkg::*;
#(
   parameter int DATA_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [1:0]            buf_cnt_o,
   output logic                  wvalid_o,
   output logic [DATA_WIDTH-1:0] wdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            cnt_q, cnt_d;
   logic                  empty, do_write, do_read;

   // The FIFO has no output register, so arriving data is bypassed straight to
   // the W channel when the buffer is empty; it is only stored if not taken.
   assign empty    = (cnt_q == 2'd0);
   assign do_write = push_i && !(empty && pop_i);
   assign do_read  = pop_i && !empty;
   assign cnt_d    = cnt_q + {1'b0, do_write} - {1'b0, do_read};

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (do_write) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_read) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         cnt_q <= cnt_d;
      end
   end

   assign buf_cnt_o = cnt_q;
   assign wvalid_o  = !empty || push_i;
   assign wdata_o   = !empty ? mem_q[rd_ptr_q] : (push_i ? push_data_i : '0);

endmodule

// File: rtl/wr_fifo_ddr_burst.sv
// rtl/wr_fifo_ddr_burst.sv - drains the wr_fifo read side into fixed-length AXI4 write bursts
// Ports:
//   clk, rst                               : read-side clock, synchronous active-high reset
//   fifo_rd_en/_data/_empty/_water_level   : FIFO read port
//   frame_start                            : rewinds the burst pointer to BASE_ADDR
//   awaddr/awlen/awvalid/awready           : AXI write-address channel
//   wdata/wlast/wvalid/wready              : AXI write-data channel
//   bresp/bvalid/bready                    : AXI write-response channel
//   busy, resp_err                         : status (resp_err sticky until rst)
module wr_fifo_ddr_burst
   import wr_fifo_ddr_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 128,
   parameter int                    LEVEL_WIDTH  = 11,
   parameter int                    ADDR_WIDTH   = 28,
   parameter int                    BURST_LEN    = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int                    FRAME_BURSTS = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
   input  logic                   fifo_rd_empty,
   input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
   input  logic                   frame_start,
   output logic [ADDR_WIDTH-1:0]  awaddr,
   output logic [7:0]             awlen,
   output logic                   awvalid,
   input  logic                   awready,
   output logic [DATA_WIDTH-1:0]  wdata,
   output logic                   wlast,
   output logic                   wvalid,
   input  logic                   wready,
   input  logic [1:0]             bresp,
   input  logic                   bvalid,
   output logic                   bready,
   output logic                   busy,
   output logic                   resp_err
);

   localparam int BURST_B = burst_bytes(DATA_WIDTH, BURST_LEN);
   localparam int BCNT_W  = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
   logic [8:0]              req_cnt_q, req_cnt_d;
   logic [8:0]              beat_cnt_q, beat_cnt_d;
   logic                    pending_q, pending_d;
   logic                    resp_err_q, resp_err_d;
   logic                    inflight_q;
   logic [1:0]              buf_cnt;
   logic                    pop;
   logic [2:0]              occupancy;

   wr_fifo_ddr_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .push_i     (inflight_q),
      .push_data_i(fifo_rd_data),
      .pop_i      (pop),
      .buf_cnt_o  (buf_cnt),
      .wvalid_o   (wvalid),
      .wdata_o    (wdata)
   );

   assign pop = wvalid && wready;

   // Words buffered plus the one in flight, net of the beat leaving this cycle;
   // keeping this below 2 guarantees the skid buffer never overflows.
   assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};

   assign fifo_rd_en = (state_q == ST_DATA) && (req_cnt_q < 9'(BURST_LEN))
                       && !fifo_rd_empty && (occupancy < 3'd2);

   assign wlast    = wvalid && (beat_cnt_q == 9'(BURST_LEN - 1));
   assign awvalid  = (state_q == ST_ADDR);
   assign awaddr   = addr_q;
   assign awlen    = 8'(BURST_LEN - 1);
   assign bready   = (state_q == ST_RESP);
   assign busy     = (state_q != ST_IDLE);
   assign resp_err = resp_err_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      bcnt_d     = bcnt_q;
      req_cnt_d  = req_cnt_q + {8'd0, fifo_rd_en};
      beat_cnt_d = beat_cnt_q + {8'd0, pop};
      pending_d  = pending_q;
      resp_err_d = resp_err_q;

      if (state_q != ST_IDLE && frame_start) begin
         pending_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            req_cnt_d  = '0;
            beat_cnt_d = '0;
            if (frame_start) begin
               addr_d = BASE_ADDR;
               bcnt_d = '0;
            end else if (fifo_rd_water_level >= LEVEL_WIDTH'(BURST_LEN) && !pending_q) begin
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (awready) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (pop && wlast) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bvalid) begin
               state_d = ST_IDLE;
               if (bresp != 2'b00) resp_err_d = 1'b1;
               // A rewind requested during the burst takes priority over advance/wrap
               if (pending_q || frame_start) begin
                  addr_d    = BASE_ADDR;
                  bcnt_d    = '0;
                  pending_d = 1'b0;
               end else if (bcnt_q == BCNT_W'(FRAME_BURSTS - 1)) begin
                  addr_d = BASE_ADDR;
                  bcnt_d = '0;
               end else begin
                  addr_d = addr_q + ADDR_WIDTH'(BURST_B);
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= BASE_ADDR;
         bcnt_q     <= '0;
         req_cnt_q  <= '0;
         beat_cnt_q <= '0;
         pending_q  <= 1'b0;
         resp_err_q <= 1'b0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         bcnt_q     <= bcnt_d;
         req_cnt_q  <= req_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         pending_q  <= pending_d;
         resp_err_q <= resp_err_d;
         inflight_q <= fifo_rd_en;
      end
   end

endmodule

// File: doc/wr_fifo_ddr_burst.md
# wr_fifo_ddr_burst

Drains the 128-bit read side of `wr_fifo` and turns it into fixed-length AXI4 write bursts toward the DDR controller. It sits directly downstream of `wr_fifo`, in the read-clock domain. It starts a burst only when the FIFO's read water level guarantees a full burst is available. It advances a linear frame address that wraps at the frame size.

## Interface
- `DATA_WIDTH`, 128: FIFO read width and AXI data width.
- `LEVEL_WIDTH`, 11: width of `fifo_rd_water_level` (FIFO read depth width + 1).
- `ADDR_WIDTH`, 28: AXI byte-address width.
- `BURST_LEN`, 64: beats per burst, 1..256.
- `BASE_ADDR`, 0: frame start byte address; burst-aligned.
- `FRAME_BURSTS`, 1024: bursts per frame before the address wraps.

Ports (clock and reset first):
- `clk` in 1: single clock, same as the FIFO `rd_clk`.
- `rst` in 1: synchronous, active-high reset.
- `fifo_rd_en` out 1: FIFO read strobe.
- `fifo_rd_data` in DATA_WIDTH: FIFO read data, valid 1 cycle after `fifo_rd_en`. The FIFO has no output register.
- `fifo_rd_empty` in 1: FIFO empty flag.
- `fifo_rd_water_level` in LEVEL_WIDTH: FIFO occupancy in read words.
- `frame_start` in 1: pulse that rewinds the address to `BASE_ADDR`.
- `awaddr` out ADDR_WIDTH, `awlen` out 8, `awvalid` out 1, `awready` in 1: AXI write-address channel.
- `wdata` out DATA_WIDTH, `wlast` out 1, `wvalid` out 1, `wready` in 1: AXI write-data channel.
- `bresp` in 2, `bvalid` in 1, `bready` out 1: AXI write-response channel.
- `busy` out 1: high whenever the state is not IDLE.
- `resp_err` out 1: sticky flag, set when `bresp` is nonzero; cleared only by `rst`.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- **IDLE → ADDR:** when `fifo_rd_water_level >= BURST_LEN` and no frame rewind is pending application.
- **ADDR → DATA:** on `awvalid && awready`.
- **DATA → RESP:** on the handshake of the beat carrying `wlast`.
- **RESP → IDLE:** on `bvalid` (`bready` is high in RESP).
- `awlen` is always BURST_LEN-1. `awaddr` holds the burst pointer, registered.
- **Address step:** after each response the pointer advances by BURST_LEN*DATA_WIDTH/8 bytes. After FRAME_BURSTS bursts it wraps to BASE_ADDR. The burst counter is ceil(log2(FRAME_BURSTS)) bits.
- **frame_start in IDLE:** pointer becomes BASE_ADDR on the next cycle. No burst starts in that cycle.
- **frame_start in any other state:** latched as pending and applied in the RESP → IDLE cycle, overriding the normal advance and wrap.
- **Read control:** reads happen only in DATA, bounded by `req_cnt < BURST_LEN`. A 2-entry skid buffer absorbs the 1-cycle read latency.
  - `fifo_rd_en = DATA && req_cnt<BURST_LEN && !fifo_rd_empty && (buf_cnt + inflight - (wvalid&&wready)) < 2`.
  - This sustains 1 beat/cycle while `wready` stays high.
- `fifo_rd_empty` gating is defensive only. The water-level check makes empty mid-burst impossible with a correct FIFO.
- **Beat counting:** `wlast` is asserted on beat index BURST_LEN-1, counted on the output handshake. No data is read beyond the burst.
- **Reset:** `rst` mid-burst returns to IDLE and clears the pointer, counters, skid buffer and pending flag. The FIFO is reset by the same system reset; this block does not flush it.

## Timing
- Reset values: `fifo_rd_en`=0, `awvalid`=0, `awaddr`=BASE_ADDR, `awlen`=BURST_LEN-1, `wvalid`=0, `wlast`=0, `wdata`=0, `bready`=0, `busy`=0, `resp_err`=0.
- Water-level condition true at cycle N → `awvalid` high at N+1. `awvalid` holds until `awready`.
- First `fifo_rd_en` in the first DATA cycle D. First `wvalid` at D+1.
- With `wready` constantly high: beats on D+1 .. D+BURST_LEN, and `wlast` at D+BURST_LEN.
- `wdata`, `wvalid` and `wlast` stay stable while `wvalid && !wready`.
- Back-to-back bursts: minimum 2 cycles from the RESP exit to the next `awvalid` (one IDLE cycle).

## Structure
- Package `wr_fifo_ddr_pkg`: FSM state enum, and the localparams BYTES_PER_BEAT, BURST_BYTES and FRAME_BYTES.
- Sub-module `wr_fifo_ddr_skid`: 2-entry skid FIFO with push = delayed `fifo_rd_en`, pop = `wvalid && wready`, and outputs `buf_cnt`, `wvalid`, `wdata`.
- The top level holds the FSM, counters and address logic.

## Test plan
- **Single burst:** pre-fill a FIFO model with 64 words 0..63, `wready`=1, `awready` at first sight of `awvalid` → one burst with awaddr=0, awlen=63, `wdata` 0..63, `wlast` only on beat 63, `bready` high in RESP.
- **Below threshold:** level=63 → `awvalid` never rises. Raise level to 64 → `awvalid` exactly 1 cycle later.
- **Random `wready` backpressure (50%) over 4 bursts:** no dropped or duplicated beats, data stable while stalled, `fifo_rd_en` count = 256 exactly.
- **Wrap:** FRAME_BURSTS=4, BASE_ADDR=0x100000, 5 bursts → awaddr sequence 0x100000, 0x100400, 0x100800, 0x100C00, 0x100000.
- **frame_start mid-DATA of burst 2:** the next awaddr = BASE_ADDR. Separately, `bresp`=2'b10 on burst 1 → `resp_err`=1 and stays set.
- **`rst` at beat 30 of a burst:** all outputs return to reset values the next cycle, and the next burst restarts at BASE_ADDR with beat count 0.
